// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants and helper functions for the Gray pointer decoder
package gray_pkg;

  localparam int ERR_CNT_W = 8;

  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  localparam err_cnt_t ERR_CNT_MAX = '1;

  // Full-width reference decode; narrower pointers are zero-extended, which leaves the result unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // Bits per pipeline segment; trailing segments may be empty and just add a register stage.
  function automatic int seg_width(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

endpackage

// File: rtl/gray2bin_seg.sv
// rtl/gray2bin_seg.sv - one registered slice of the MSB-first Gray-to-binary XOR chain
module gray2bin_seg #(
  parameter int WIDTH = 5,
  parameter int HI    = 4,
  parameter int LO    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_d,
  input  logic [WIDTH-1:0] gray_d,
  input  logic             valid_d,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             valid_q
);

  // Carry enters from the bit just above this slice; an empty slice (HI < 0) never uses it.
  localparam int CI = (HI < 0) ? 0 : HI + 1;

  logic [WIDTH:0]   ext;
  logic             carry;
  logic [WIDTH-1:0] bin_next;

  // Decode bits HI..LO, continuing the chain from the already-decoded upper bits.
  always_comb begin
    ext      = {1'b0, bin_d};
    carry    = ext[CI];
    bin_next = bin_d;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i <= HI && i >= LO) begin
        carry       = carry ^ gray_d[i];
        bin_next[i] = carry;
      end
    end
  end

  // Register partial binary, the Gray remainder and the qualifier; reset drops any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      bin_q   <= bin_next;
      gray_q  <= gray_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/gray_ptr_decoder.sv
// rtl/gray_ptr_decoder.sv - pipelined Gray pointer decoder with step report; GRAY_PTR_DECODER_STEP_CHECK_EN adds the illegal-step checker
module gray_ptr_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     gray_i,
  input  logic                 gray_valid_i,
  input  logic                 err_clr_i,
  output logic [WIDTH-1:0]     bin_o,
  output logic                 bin_valid_o,
  output logic [WIDTH-1:0]     step_o,
  output logic                 step_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int SW = seg_width(WIDTH, STAGES);

  logic [STAGES:0][WIDTH-1:0] bin_p;
  logic [STAGES:0][WIDTH-1:0] gray_p;
  logic [STAGES:0]            valid_p;

  assign bin_p[0]   = '0;
  assign gray_p[0]  = gray_i;
  assign valid_p[0] = gray_valid_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int HI     = WIDTH - 1 - k * SW;
    localparam int LO_RAW = WIDTH - (k + 1) * SW;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    gray2bin_seg #(
      .WIDTH (WIDTH),
      .HI    (HI),
      .LO    (LO)
    ) u_seg (
      .clk     (clk_i),
      .rst     (rst_i),
      .bin_d   (bin_p[k]),
      .gray_d  (gray_p[k]),
      .valid_d (valid_p[k]),
      .bin_q   (bin_p[k+1]),
      .gray_q  (gray_p[k+1]),
      .valid_q (valid_p[k+1])
    );
  end

  logic unused_gray;
  assign unused_gray = ^gray_p[STAGES];

  logic             last_valid;
  logic [WIDTH-1:0] bin_hold;
  logic [WIDTH-1:0] step_hold;
  logic [WIDTH-1:0] step_now;
  logic             out_first;

  assign last_valid = valid_p[STAGES];

  // Step against the last delivered value; modulo wrap falls out of WIDTH-bit subtraction.
  always_comb begin
    step_now = '0;
    if (!out_first) begin
      step_now = bin_p[STAGES] - bin_hold;
    end
  end

  assign bin_valid_o = last_valid;
  assign bin_o       = last_valid ? bin_p[STAGES] : bin_hold;
  assign step_o      = last_valid ? step_now : step_hold;

  // Hold the delivered value and step so outputs stay put across bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_hold  <= '0;
      step_hold <= '0;
      out_first <= 1'b1;
    end else if (last_valid) begin
      bin_hold  <= bin_p[STAGES];
      step_hold <= step_now;
      out_first <= 1'b0;
    end
  end

`ifdef GRAY_PTR_DECODER_STEP_CHECK_EN
  logic [WIDTH-1:0]  prev_gray;
  logic              in_first;
  logic              err_in;
  logic [STAGES-1:0] err_pipe;
  err_cnt_t          err_cnt;

  // More than one changed bit between accepted samples cannot be a legal Gray step.
  always_comb begin
    err_in = 1'b0;
    if (!in_first) begin
      err_in = popcount(32'(gray_i ^ prev_gray)) > 1;
    end
  end

  // Track the previous accepted sample, erroneous ones included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_gray <= '0;
      in_first  <= 1'b1;
    end else if (gray_valid_i) begin
      prev_gray <= gray_i;
      in_first  <= 1'b0;
    end
  end

  // Carry the error flag alongside its sample through the decode pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pipe <= '0;
    end else begin
      err_pipe <= STAGES'({err_pipe, err_in & gray_valid_i});
    end
  end

  assign step_err_o = last_valid & err_pipe[STAGES-1];

  // Saturating error counter; a clear beats an increment in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (err_clr_i) begin
      err_cnt <= '0;
    end else if (step_err_o && err_cnt != ERR_CNT_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  logic unused_clr;
  assign unused_clr = err_clr_i;

  assign step_err_o = 1'b0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// tb/tb_gray_ptr_decoder.sv - directed self-checking bench for gray_ptr_decoder
module tb_gray_ptr_decoder;

`ifdef GRAY_PTR_DECODER_STEP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] gray_i;
  logic       gray_valid_i;
  logic       err_clr_i;

  logic [4:0] bin_o, step_o;
  logic       bin_valid_o, step_err_o;
  logic [7:0] err_cnt_o;

  logic [4:0] bin1, step1;
  logic       bv1, se1;
  logic [7:0] ec1;

  logic [4:0] bin5, step5;
  logic       bv5, se5;
  logic [7:0] ec5;

  int total = 0;
  int bad   = 0;
  logic [4:0] g5;
  int n;

  int d_v[6]    = '{1, 0, 0, 1, 0, 0};
  int d_g[6]    = '{3, 31, 31, 2, 0, 0};
  int e_v[6]    = '{0, 1, 0, 0, 1, 0};
  int e_bin[6]  = '{0, 2, 2, 2, 3, 3};
  int e_step[6] = '{0, 0, 0, 0, 1, 1};

  always #5 clk = ~clk;

  gray_ptr_decoder #(.WIDTH(5), .STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .gray_i(gray_i), .gray_valid_i(gray_valid_i),
    .err_clr_i(err_clr_i), .bin_o(bin_o), .bin_valid_o(bin_valid_o),
    .step_o(step_o), .step_err_o(step_err_o), .err_cnt_o(err_cnt_o)
  );

  gray_ptr_decoder #(.WIDTH(5), .STAGES(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .gray_i(gray_i), .gray_valid_i(gray_valid_i),
    .err_clr_i(err_clr_i), .bin_o(bin1), .bin_valid_o(bv1),
    .step_o(step1), .step_err_o(se1), .err_cnt_o(ec1)
  );

  gray_ptr_decoder #(.WIDTH(5), .STAGES(5)) dut5 (
    .clk_i(clk), .rst_i(rst_i), .gray_i(gray_i), .gray_valid_i(gray_valid_i),
    .err_clr_i(err_clr_i), .bin_o(bin5), .bin_valid_o(bv5),
    .step_o(step5), .step_err_o(se5), .err_cnt_o(ec5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    gray_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    gray_i = '0;
    gray_valid_i = 1'b0;
    err_clr_i = 1'b0;
    tick();
    tick();
    tick();

    check("rst bin", bin_o, 0);
    check("rst valid", bin_valid_o, 0);
    check("rst step", step_o, 0);
    check("rst err", step_err_o, 0);
    check("rst cnt", err_cnt_o, 0);
    check("rst valid s1", bv1, 0);
    check("rst valid s5", bv5, 0);
    rst_i = 1'b0;

    // Gray count 0..31 then 0, one per cycle
    for (int i = 0; i < 36; i++) begin
      if (i < 33) begin
        g5 = 5'(i);
        gray_i = g5 ^ (g5 >> 1);
        gray_valid_i = 1'b1;
      end else begin
        gray_valid_i = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 33) begin
        n = i - 1;
        check("cnt valid", bin_valid_o, 1);
        check("cnt bin", bin_o, n % 32);
        check("cnt step", step_o, (n == 0) ? 0 : 1);
        check("cnt err", step_err_o, 0);
      end else if (i >= 34) begin
        check("cnt idle valid", bin_valid_o, 0);
        check("cnt hold bin", bin_o, 0);
        check("cnt hold step", step_o, 1);
      end
    end

    // Single sample 10000 through 1, 2 and 5 stage variants
    pulse_reset();
    check("post rst bin", bin_o, 0);
    check("post rst step", step_o, 0);
    gray_i = 5'b10000;
    gray_valid_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      gray_valid_i = 1'b0;
      check("lat s1", bv1, (c == 1) ? 1 : 0);
      check("lat s2", bin_valid_o, (c == 2) ? 1 : 0);
      check("lat s5", bv5, (c == 5) ? 1 : 0);
    end
    check("msb bin s1", bin1, 31);
    check("msb bin s2", bin_o, 31);
    check("msb bin s5", bin5, 31);
    check("msb step s1", step1, 0);
    check("msb step s2", step_o, 0);
    check("msb step s5", step5, 0);
    check("msb err s1", se1, 0);
    check("msb err s5", se5, 0);
    check("msb cnt s1", ec1, 0);
    check("msb cnt s5", ec5, 0);

    // Two-bit jump 00000 -> 00011
    pulse_reset();
    gray_i = 5'b00000;
    gray_valid_i = 1'b1;
    tick();
    gray_i = 5'b00011;
    tick();
    gray_valid_i = 1'b0;
    check("jump0 valid", bin_valid_o, 1);
    check("jump0 bin", bin_o, 0);
    check("jump0 step", step_o, 0);
    check("jump0 err", step_err_o, 0);
    tick();
    check("jump1 valid", bin_valid_o, 1);
    check("jump1 bin", bin_o, 2);
    check("jump1 step", step_o, 2);
    check("jump1 err", step_err_o, CHK);
    check("jump1 cnt", err_cnt_o, 0);
    tick();
    check("jump cnt next", err_cnt_o, CHK ? 1 : 0);
    check("jump idle valid", bin_valid_o, 0);
    check("jump idle err", step_err_o, 0);
    check("jump hold bin", bin_o, 2);
    check("jump hold step", step_o, 2);

    // Valid pattern 1,0,0,1 with repeated sample and ignored bubble data
    for (int j = 0; j < 6; j++) begin
      gray_valid_i = d_v[j][0];
      gray_i = 5'(d_g[j]);
      tick();
      if (j >= 1) begin
        check("gap valid", bin_valid_o, e_v[j]);
        check("gap bin", bin_o, e_bin[j]);
        check("gap step", step_o, e_step[j]);
        check("gap err", step_err_o, 0);
      end
    end
    check("gap cnt", err_cnt_o, CHK ? 1 : 0);

    // Reset with two samples in flight
    gray_i = 5'b00001;
    gray_valid_i = 1'b1;
    tick();
    gray_i = 5'b00011;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    gray_valid_i = 1'b0;
    check("mid rst bin", bin_o, 0);
    check("mid rst valid", bin_valid_o, 0);
    check("mid rst step", step_o, 0);
    check("mid rst err", step_err_o, 0);
    check("mid rst cnt", err_cnt_o, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid rst flushed", bin_valid_o, 0);
    end
    gray_i = 5'b00110;
    gray_valid_i = 1'b1;
    tick();
    gray_valid_i = 1'b0;
    tick();
    check("after rst valid", bin_valid_o, 1);
    check("after rst bin", bin_o, 4);
    check("after rst step", step_o, 0);
    check("after rst err", step_err_o, 0);

    // Saturation: 300 consecutive two-bit jumps
    pulse_reset();
    for (int k = 0; k <= 300; k++) begin
      gray_i = (k % 2 == 1) ? 5'b00011 : 5'b00000;
      gray_valid_i = 1'b1;
      tick();
    end
    gray_valid_i = 1'b0;
    tick();
    tick();
    tick();
    check("sat cnt", err_cnt_o, CHK ? 255 : 0);

    // Clear coinciding with an error
    gray_i = 5'b00011;
    gray_valid_i = 1'b1;
    tick();
    gray_valid_i = 1'b0;
    tick();
    check("clr err valid", bin_valid_o, 1);
    check("clr err flag", step_err_o, CHK);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("clr wins", err_cnt_o, 0);

    gray_i = 5'b00000;
    gray_valid_i = 1'b1;
    tick();
    gray_valid_i = 1'b0;
    tick();
    check("recount err", step_err_o, CHK);
    tick();
    check("recount cnt", err_cnt_o, CHK ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
